// File: rtl/soc_arb2_if.sv
// Bus bundle for soc_arb2: two requesting masters (m0 = CPU data, m1 = UART loader) and one shared slave.
// Modport master is the arbiter's view; modport slave is the view of the surrounding masters and slave device.
interface soc_arb2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            m0_vld;
    logic            m0_we;
    logic [AW-1:0]   m0_addr;
    logic [DW-1:0]   m0_wdat;
    logic [DW/8-1:0] m0_be;
    logic            m0_rdy;
    logic [DW-1:0]   m0_rdat;
    logic            m0_err;

    logic            m1_vld;
    logic            m1_we;
    logic [AW-1:0]   m1_addr;
    logic [DW-1:0]   m1_wdat;
    logic [DW/8-1:0] m1_be;
    logic            m1_rdy;
    logic [DW-1:0]   m1_rdat;
    logic            m1_err;

    logic            s_vld;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdat;
    logic [DW/8-1:0] s_be;
    logic            s_rdy;
    logic [DW-1:0]   s_rdat;

    modport master (
        input  m0_vld, m0_we, m0_addr, m0_wdat, m0_be,
        output m0_rdy, m0_rdat, m0_err,
        input  m1_vld, m1_we, m1_addr, m1_wdat, m1_be,
        output m1_rdy, m1_rdat, m1_err,
        output s_vld, s_we, s_addr, s_wdat, s_be,
        input  s_rdy, s_rdat
    );

    modport slave (
        output m0_vld, m0_we, m0_addr, m0_wdat, m0_be,
        input  m0_rdy, m0_rdat, m0_err,
        output m1_vld, m1_we, m1_addr, m1_wdat, m1_be,
        input  m1_rdy, m1_rdat, m1_err,
        input  s_vld, s_we, s_addr, s_wdat, s_be,
        output s_rdy, s_rdat
    );
endinterface

// File: rtl/soc_arb2.sv
// Two-master, one-slave arbiter with whole-transaction grants and a bus watchdog.
// Define SOC_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module soc_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    soc_arb2_if.master  bus,
    output logic [1:0]  grant
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    if ((DW % 8) != 0 || AW < 1) begin : g_bad_param
        $error("soc_arb2: DW must be a multiple of 8 and AW positive");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          timeout_hit;
    logic          tie_pick1;
    logic          sel1;
    logic          done;
    logic          abort;

`ifdef SOC_ARB_RR_EN
    logic last, last_nxt;

    // last == 1 means master 1 was served most recently, so master 0 takes the tie
    assign tie_pick1 = ~last;
`else
    assign tie_pick1 = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TMO);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef SOC_ARB_RR_EN
            last  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
`ifdef SOC_ARB_RR_EN
            last  <= last_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
`ifdef SOC_ARB_RR_EN
        last_nxt    = last;
`endif
        grant       = '0;
        sel1        = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;
        bus.s_vld   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_addr  = '0;
        bus.s_wdat  = '0;
        bus.s_be    = '0;
        bus.m0_rdy  = 1'b0;
        bus.m0_err  = 1'b0;
        bus.m0_rdat = '0;
        bus.m1_rdy  = 1'b0;
        bus.m1_err  = 1'b0;
        bus.m1_rdat = '0;

        case (state)
            IDLE: begin
                if (bus.m0_vld && (!bus.m1_vld || !tie_pick1)) begin
                    state_nxt = GNT0;
`ifdef SOC_ARB_RR_EN
                    last_nxt  = 1'b0;
`endif
                end else if (bus.m1_vld) begin
                    state_nxt = GNT1;
`ifdef SOC_ARB_RR_EN
                    last_nxt  = 1'b1;
`endif
                end
            end

            GNT0, GNT1: begin
                sel1       = (state == GNT1);
                grant      = sel1 ? 2'b10 : 2'b01;
                bus.s_vld  = 1'b1;
                bus.s_we   = sel1 ? bus.m1_we   : bus.m0_we;
                bus.s_addr = sel1 ? bus.m1_addr : bus.m0_addr;
                bus.s_wdat = sel1 ? bus.m1_wdat : bus.m0_wdat;
                bus.s_be   = sel1 ? bus.m1_be   : bus.m0_be;

                // slave acknowledge beats a coincident timeout; reset drops the transaction silently
                done  = bus.s_rdy && !sys_rst;
                abort = !bus.s_rdy && timeout_hit && !sys_rst;

                if (bus.s_rdy || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
                end

                if (sel1) begin
                    bus.m1_rdy  = done || abort;
                    bus.m1_err  = abort;
                    bus.m1_rdat = done ? bus.s_rdat : '0;
                end else begin
                    bus.m0_rdy  = done || abort;
                    bus.m0_err  = abort;
                    bus.m0_rdat = done ? bus.s_rdat : '0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_soc_arb2.sv
// Scoreboard bench for soc_arb2: directed requests push expected completions, a negedge monitor pops and checks them.
// Tie-breaking expectations follow SOC_ARB_RR_EN the same way the design build does.
module tb_soc_arb2;
    logic       clk;
    logic       rst;
    logic [1:0] grant;

    soc_arb2_if #(.AW(32), .DW(32)) bus ();

    soc_arb2 #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus),
        .grant   (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: acknowledges slave_lat cycles after s_vld rises; force_rdy injects a stray acknowledge
    int          wcnt;
    int          slave_lat;
    logic        slave_en;
    logic        force_rdy;
    logic [31:0] slave_rdat;

    always @(posedge clk) begin
        if (!bus.s_vld || bus.s_rdy) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    assign bus.s_rdy  = force_rdy | (slave_en & bus.s_vld & (wcnt == slave_lat));
    assign bus.s_rdat = slave_rdat;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic err, input logic [31:0] rdat);
        exp_t e;
        e.idx  = idx;
        e.err  = err;
        e.rdat = rdat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!bus.m0_rdy) check("m0_quiet", {31'd0, bus.m0_err, bus.m0_rdat}, 64'd0);
        if (!bus.m1_rdy) check("m1_quiet", {31'd0, bus.m1_err, bus.m1_rdat}, 64'd0);
        if (bus.m0_rdy || bus.m1_rdy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rdy: got m0_rdy=%b m1_rdy=%b, required no completion (t=%0t)",
                         bus.m0_rdy, bus.m1_rdy, $time);
            end else begin
                mon_e = sb.pop_front();
                check("rdy_master", {62'd0, bus.m1_rdy, bus.m0_rdy}, (mon_e.idx == 1) ? 64'd2 : 64'd1);
                check("rdy_err", {63'd0, bus.m1_rdy ? bus.m1_err : bus.m0_err}, {63'd0, mon_e.err});
                check("rdy_rdat", {32'd0, bus.m1_rdy ? bus.m1_rdat : bus.m0_rdat}, {32'd0, mon_e.rdat});
            end
        end
    end

    int          vcount;
    logic [1:0]  tie_grants [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        slave_en = 1'b0;
        slave_lat = 0;
        force_rdy = 1'b0;
        slave_rdat = 32'h0;
        bus.m0_vld = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdat = '0; bus.m0_be = '0;
        bus.m1_vld = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdat = '0; bus.m1_be = '0;

        tick();
        tick();
        rst = 1'b0;
        #2;
        check("reset_grant", {62'd0, grant}, 64'd0);
        check("reset_svld", {63'd0, bus.s_vld}, 64'd0);

        // Single read from m0, slave acknowledges two cycles after s_vld
        tick();
        bus.m0_vld = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h100; bus.m0_be = 4'hF;
        slave_en = 1'b1; slave_lat = 2; slave_rdat = 32'hDEADBEEF;
        push(0, 1'b0, 32'hDEADBEEF);
        #2;
        check("rd_t0_grant", {62'd0, grant}, 64'd0);
        tick();
        #2;
        check("rd_t1_svld", {63'd0, bus.s_vld}, 64'd1);
        check("rd_t1_grant", {62'd0, grant}, 64'd1);
        check("rd_t1_addr", {32'd0, bus.s_addr}, 64'h100);
        tick();
        #2;
        check("rd_t2_rdy", {63'd0, bus.m0_rdy}, 64'd0);
        tick();
        #2;
        check("rd_t3_rdy", {63'd0, bus.m0_rdy}, 64'd1);
        check("rd_t3_rdat", {32'd0, bus.m0_rdat}, 64'hDEADBEEF);
        tick();
        bus.m0_vld = 1'b0;
        #2;
        check("rd_t4_grant", {62'd0, grant}, 64'd0);

        // Write from m1, attributes pass straight through while granted
        tick();
        bus.m1_vld = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h2000_0004;
        bus.m1_wdat = 32'h12345678; bus.m1_be = 4'b0101;
        slave_lat = 1; slave_rdat = 32'h0BADF00D;
        push(1, 1'b0, 32'h0BADF00D);
        tick();
        #2;
        check("wr_grant", {62'd0, grant}, 64'd2);
        check("wr_svld", {63'd0, bus.s_vld}, 64'd1);
        check("wr_we", {63'd0, bus.s_we}, 64'd1);
        check("wr_addr", {32'd0, bus.s_addr}, 64'h2000_0004);
        check("wr_wdat", {32'd0, bus.s_wdat}, 64'h12345678);
        check("wr_be", {60'd0, bus.s_be}, 64'h5);
        tick();
        #2;
        check("wr_rdy", {63'd0, bus.m1_rdy}, 64'd1);
        check("wr_wdat_hold", {32'd0, bus.s_wdat}, 64'h12345678);
        tick();
        bus.m1_vld = 1'b0;
        #2;
        check("wr_idle_we", {63'd0, bus.s_we}, 64'd0);
        check("wr_idle_addr", {32'd0, bus.s_addr}, 64'd0);
        check("wr_idle_wdat", {32'd0, bus.s_wdat}, 64'd0);
        check("wr_idle_be", {60'd0, bus.s_be}, 64'd0);
        check("wr_idle_grant", {62'd0, grant}, 64'd0);

        // Watchdog: TIMEOUT=4, slave never answers
        tick();
        bus.m1_vld = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h40;
        slave_en = 1'b0; slave_rdat = 32'hFFFFFFFF;
        push(1, 1'b1, 32'h0);
        vcount = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            #2;
            vcount += int'(bus.s_vld);
            if (i == 5) begin
                check("wd_rdy", {63'd0, bus.m1_rdy}, 64'd1);
                check("wd_err", {63'd0, bus.m1_err}, 64'd1);
            end else begin
                check("wd_early_rdy", {63'd0, bus.m1_rdy}, 64'd0);
            end
        end
        tick();
        bus.m1_vld = 1'b0;
        force_rdy = 1'b1;
        #2;
        vcount += int'(bus.s_vld);
        check("wd_late_rdy", {63'd0, bus.m1_rdy}, 64'd0);
        check("wd_svld_cycles", 64'(vcount), 64'd5);
        tick();
        force_rdy = 1'b0;

        // Reset pulsed while m0 owns the bus
        tick();
        bus.m0_vld = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h300;
        tick();
        #2;
        check("rst_pre_grant", {62'd0, grant}, 64'd1);
        tick();
        rst = 1'b1;
        force_rdy = 1'b1;
        #2;
        check("rst_cycle_rdy", {63'd0, bus.m0_rdy}, 64'd0);
        tick();
        rst = 1'b0;
        force_rdy = 1'b0;
        #2;
        check("rst_post_svld", {63'd0, bus.s_vld}, 64'd0);
        check("rst_post_grant", {62'd0, grant}, 64'd0);
        check("rst_post_rdy", {63'd0, bus.m0_rdy}, 64'd0);

        // Tie with zero-wait slave, starting in this IDLE cycle
        bus.m1_vld = 1'b1;
        slave_en = 1'b1; slave_lat = 0; slave_rdat = 32'h5555AAAA;
`ifdef SOC_ARB_RR_EN
        tie_grants = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        push(0, 1'b0, 32'h5555AAAA);
        push(1, 1'b0, 32'h5555AAAA);
        push(0, 1'b0, 32'h5555AAAA);
        push(1, 1'b0, 32'h5555AAAA);
`else
        tie_grants = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) push(0, 1'b0, 32'h5555AAAA);
`endif
        for (int i = 0; i < 8; i++) begin
            tick();
            #2;
            check("tie_grant", {62'd0, grant}, {62'd0, tie_grants[i]});
            if (i == 7) begin
                bus.m0_vld = 1'b0;
                bus.m1_vld = 1'b0;
            end
        end
        tick();
        tick();
        #2;
        check("end_grant", {62'd0, grant}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
